// File: rtl/pipe_ctrl.sv
// Pipeline sequencer: merges stage stall requests, runs exception redirect (IDLE->WAIT->FLUSH).
// Stall is combinational in the request cycle; redirect flush lands one cycle after exc_req when the bus is idle.
module pipe_ctrl #(
  parameter int CNT_W        = 32,
  parameter int WAIT_TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stallreq_if,
  input  logic             stallreq_id,
  input  logic             stallreq_ex,
  input  logic             stallreq_mem,
  input  logic             exc_req,
  input  logic [31:0]      exc_pc,
  input  logic             bus_busy,
  input  logic             cnt_clr,
  output logic [5:0]       stall,
  output logic             flush,
  output logic [31:0]      new_pc,
  output logic [CNT_W-1:0] stall_cycles,
  output logic             err_timeout
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    FLUSH = 2'd2
  } state_t;

  localparam int WW = (WAIT_TIMEOUT < 2) ? 1 : $clog2(WAIT_TIMEOUT + 1);
  localparam logic [WW-1:0] WAIT_LAST = WW'(WAIT_TIMEOUT - 1);

  localparam logic [5:0] STALL_MEM = 6'b011111;
  localparam logic [5:0] STALL_EX  = 6'b001111;
  localparam logic [5:0] STALL_ID  = 6'b000111;
  localparam logic [5:0] STALL_IF  = 6'b000011;

  state_t        state_q, state_d;
  logic [WW-1:0] wait_q, wait_d;
  logic [31:0]   pc_q, pc_d;
  logic [5:0]    stall_c;
  logic          timeout_set;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      wait_q  <= '0;
      pc_q    <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      pc_q    <= pc_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    wait_d      = wait_q;
    pc_d        = pc_q;
    stall_c     = 6'b000000;
    flush       = 1'b0;
    new_pc      = 32'h0;
    timeout_set = 1'b0;
    case (state_q)
      IDLE: begin
        if (exc_req) begin
          // Freeze through MEM so the excepting instruction never reaches WB
          stall_c = STALL_MEM;
          pc_d    = exc_pc;
          if (bus_busy) begin
            state_d = WAIT;
            wait_d  = '0;
          end else begin
            state_d = FLUSH;
          end
        end else if (stallreq_mem) begin
          stall_c = STALL_MEM;
        end else if (stallreq_ex) begin
          stall_c = STALL_EX;
        end else if (stallreq_id) begin
          stall_c = STALL_ID;
        end else if (stallreq_if) begin
          stall_c = STALL_IF;
        end
      end
      WAIT: begin
        stall_c = STALL_MEM;
        if (!bus_busy) begin
          state_d = FLUSH;
        end else if (wait_q == WAIT_LAST) begin
          timeout_set = 1'b1;
          state_d     = FLUSH;
        end else begin
          wait_d = wait_q + WW'(1);
        end
      end
      FLUSH: begin
        flush   = 1'b1;
        new_pc  = pc_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Requests may be high while reset is held; keep the vector quiet regardless
  assign stall = reset ? 6'b000000 : stall_c;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cycles <= '0;
      err_timeout  <= 1'b0;
    end else begin
      if (timeout_set) err_timeout <= 1'b1;
      if (cnt_clr) begin
        stall_cycles <= '0;
      end else if ((stall != 6'b000000) && (stall_cycles != {CNT_W{1'b1}})) begin
        stall_cycles <= stall_cycles + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: default instance plus a small one (CNT_W=4, WAIT_TIMEOUT=4).
module tb_pipe_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        sr_if, sr_id, sr_ex, sr_mem;
  logic        exc_req;
  logic [31:0] exc_pc;
  logic        bus_busy;
  logic        cnt_clr;

  logic [5:0]  stall0, stall1;
  logic        flush0, flush1;
  logic [31:0] npc0, npc1;
  logic [31:0] cyc0;
  logic [3:0]  cyc1;
  logic        to0, to1;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] pc;
  } exp_t;
  exp_t sb[$];

  localparam logic [3:0] R_NONE = 4'b0000;
  localparam logic [3:0] R_IF   = 4'b0001;
  localparam logic [3:0] R_ID   = 4'b0010;
  localparam logic [3:0] R_EX   = 4'b0100;
  localparam logic [3:0] R_MEM  = 4'b1000;

  always #5 clk = ~clk;

  pipe_ctrl u0 (
    .clk(clk), .reset(reset),
    .stallreq_if(sr_if), .stallreq_id(sr_id), .stallreq_ex(sr_ex), .stallreq_mem(sr_mem),
    .exc_req(exc_req), .exc_pc(exc_pc), .bus_busy(bus_busy), .cnt_clr(cnt_clr),
    .stall(stall0), .flush(flush0), .new_pc(npc0), .stall_cycles(cyc0), .err_timeout(to0)
  );

  pipe_ctrl #(.CNT_W(4), .WAIT_TIMEOUT(4)) u1 (
    .clk(clk), .reset(reset),
    .stallreq_if(sr_if), .stallreq_id(sr_id), .stallreq_ex(sr_ex), .stallreq_mem(sr_mem),
    .exc_req(exc_req), .exc_pc(exc_pc), .bus_busy(bus_busy), .cnt_clr(cnt_clr),
    .stall(stall1), .flush(flush1), .new_pc(npc1), .stall_cycles(cyc1), .err_timeout(to1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of stimulus, queue its expected outputs, compare before the next edge.
  task automatic step(input logic [3:0] sr, input logic ex, input logic [31:0] pc,
                      input logic bb, input logic clr, input logic sel,
                      input logic [5:0] es, input logic ef, input logic [31:0] ep);
    exp_t e;
    @(negedge clk);
    {sr_mem, sr_ex, sr_id, sr_if} = sr;
    exc_req  = ex;
    exc_pc   = pc;
    bus_busy = bb;
    cnt_clr  = clr;
    sb.push_back('{stall: es, flush: ef, pc: ep});
    #2;
    e = sb.pop_front();
    if (sel) begin
      chk("stall_b", 32'(stall1), 32'(e.stall));
      chk("flush_b", 32'(flush1), 32'(e.flush));
      chk("new_pc_b", npc1, e.pc);
    end else begin
      chk("stall", 32'(stall0), 32'(e.stall));
      chk("flush", 32'(flush0), 32'(e.flush));
      chk("new_pc", npc0, e.pc);
    end
  endtask

  task automatic after_edge();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    {sr_mem, sr_ex, sr_id, sr_if} = R_ID;
    exc_req = 1'b0; exc_pc = 32'h0; bus_busy = 1'b0; cnt_clr = 1'b0;
    #3;
    chk("rst_stall", 32'(stall0), 32'h0);
    chk("rst_flush", 32'(flush0), 32'h0);
    chk("rst_new_pc", npc0, 32'h0);
    chk("rst_cycles", cyc0, 32'h0);
    chk("rst_timeout", 32'(to0), 32'h0);
    @(negedge clk);
    {sr_mem, sr_ex, sr_id, sr_if} = R_NONE;
    @(negedge clk);
    reset = 1'b0;

    // stall priority
    step(R_ID,          0, 0, 0, 0, 0, 6'b000111, 0, 0);
    step(R_ID | R_MEM,  0, 0, 0, 0, 0, 6'b011111, 0, 0);
    step(R_EX | R_IF,   0, 0, 0, 0, 0, 6'b001111, 0, 0);
    step(R_IF,          0, 0, 0, 0, 0, 6'b000011, 0, 0);
    step(R_NONE,        0, 0, 0, 0, 0, 6'b000000, 0, 0);

    // redirect with idle bus; stall requests ignored during FLUSH
    step(R_NONE, 1, 32'hBFC00380, 0, 0, 0, 6'b011111, 0, 32'h0);
    step(R_MEM,  0, 32'h0,        0, 0, 0, 6'b000000, 1, 32'hBFC00380);
    step(R_NONE, 0, 32'h0,        0, 0, 0, 6'b000000, 0, 32'h0);

    // busy bus for 5 cycles, stray exc_req in WAIT, then back-to-back redirect
    step(R_NONE, 1, 32'hA0000000, 1, 0, 0, 6'b011111, 0, 0);
    step(R_ID,   1, 32'h12345678, 1, 0, 0, 6'b011111, 0, 0);
    step(R_NONE, 0, 32'h0,        1, 0, 0, 6'b011111, 0, 0);
    step(R_NONE, 1, 32'h55555555, 1, 0, 0, 6'b011111, 0, 0);
    step(R_NONE, 0, 32'h0,        1, 0, 0, 6'b011111, 0, 0);
    step(R_NONE, 0, 32'h0,        0, 0, 0, 6'b011111, 0, 0);
    step(R_NONE, 0, 32'h0,        0, 0, 0, 6'b000000, 1, 32'hA0000000);
    step(R_NONE, 1, 32'h80000180, 0, 0, 0, 6'b011111, 0, 0);
    step(R_NONE, 0, 32'h0,        0, 0, 0, 6'b000000, 1, 32'h80000180);
    step(R_NONE, 0, 32'h0,        0, 0, 0, 6'b000000, 0, 0);
    chk("no_timeout", 32'(to0), 32'h0);

    // stall counter: clear wins over a stalled cycle, then 10 stalled cycles
    step(R_ID, 0, 0, 0, 1, 0, 6'b000111, 0, 0);
    after_edge();
    chk("cnt_cleared", cyc0, 32'd0);
    for (int i = 0; i < 10; i++) step(R_ID, 0, 0, 0, 0, 0, 6'b000111, 0, 0);
    step(R_NONE, 0, 0, 0, 0, 0, 6'b000000, 0, 0);
    chk("cnt_ten", cyc0, 32'd10);
    step(R_EX, 0, 0, 0, 1, 0, 6'b001111, 0, 0);
    after_edge();
    chk("cnt_clr_wins", cyc0, 32'd0);

    // reset in the middle of WAIT
    step(R_NONE, 1, 32'hDEADBEEF, 1, 0, 0, 6'b011111, 0, 0);
    step(R_NONE, 0, 32'h0,        1, 0, 0, 6'b011111, 0, 0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("midwait_stall", 32'(stall0), 32'h0);
    chk("midwait_flush", 32'(flush0), 32'h0);
    chk("midwait_new_pc", npc0, 32'h0);
    chk("midwait_cycles", cyc0, 32'h0);
    chk("midwait_timeout_b", 32'(to1), 32'h0);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) step(R_NONE, 0, 0, 0, 0, 0, 6'b000000, 0, 0);

    // small instance: timeout after 4 WAIT cycles, sticky error
    step(R_NONE, 1, 32'h90000000, 1, 0, 1, 6'b011111, 0, 0);
    for (int i = 0; i < 4; i++) step(R_NONE, 0, 0, 1, 0, 1, 6'b011111, 0, 0);
    step(R_NONE, 0, 0, 1, 0, 1, 6'b000000, 1, 32'h90000000);
    chk("timeout_set", 32'(to1), 32'h1);
    step(R_NONE, 0, 0, 0, 0, 1, 6'b000000, 0, 0);
    step(R_NONE, 0, 0, 0, 0, 1, 6'b000000, 0, 0);
    chk("timeout_sticky", 32'(to1), 32'h1);

    // small instance: counter saturates at 4'hF
    step(R_ID, 0, 0, 0, 1, 1, 6'b000111, 0, 0);
    for (int i = 0; i < 14; i++) step(R_ID, 0, 0, 0, 0, 1, 6'b000111, 0, 0);
    after_edge();
    chk("cnt_b_14", 32'(cyc1), 32'hE);
    for (int i = 0; i < 5; i++) step(R_ID, 0, 0, 0, 0, 1, 6'b000111, 0, 0);
    after_edge();
    chk("cnt_b_sat", 32'(cyc1), 32'hF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
